// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, iterative-unit states and constants shared by the ALU files
package alu_pkg;
  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_PASSB  = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DIV} alu_state_e;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;
  localparam logic [31:0] INT_MIN   = 32'h80000000;
  function automatic logic is_mdu(input logic [4:0] op);
    return op >= OP_MUL && op <= OP_REMU;
  endfunction
endpackage

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: 32-step shift-add multiplier / restoring divider on operand magnitudes
module alu_mdu_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] res_o
);
  alu_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] d_q, d_d;
  logic [63:0] p_q, p_d, mstep, dstep, prod;
  logic hi_q, hi_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic sa, sb, na, nb, is_mul;
  logic [32:0] msum, dsh, ddiff;
  logic [31:0] abs_a, abs_b, quo, rem;
  assign sa     = op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM;
  assign sb     = op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM;
  assign na     = sa && a_i[31];
  assign nb     = sb && b_i[31];
  assign abs_a  = na ? -a_i : a_i;
  assign abs_b  = nb ? -b_i : b_i;
  assign is_mul = op_i <= OP_MULHU;
  // one multiply step: p holds {partial high, remaining multiplier bits}
  assign msum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, d_q} : 33'd0);
  assign mstep = {msum, p_q[31:1]};
  // one restoring divide step: p holds {partial remainder, dividend/quotient bits}
  assign dsh   = {p_q[63:32], p_q[31]};
  assign ddiff = dsh - {1'b0, d_q};
  assign dstep = ddiff[32] ? {dsh[31:0], p_q[30:0], 1'b0} : {ddiff[31:0], p_q[30:0], 1'b1};
  // the final step's value feeds the result directly so it lands on the completing edge
  assign prod  = qneg_q ? -mstep : mstep;
  assign quo   = qneg_q ? -dstep[31:0] : dstep[31:0];
  assign rem   = rneg_q ? -dstep[63:32] : dstep[63:32];
  assign res_o = state_q == MUL ? (hi_q ? prod[63:32] : prod[31:0]) : (hi_q ? rem : quo);
  assign busy_o = state_q != IDLE;
  // state, counter and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      p_q     <= '0;
      hi_q    <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  // latch magnitudes and signs on start, then iterate 32 times
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    p_d     = p_q;
    hi_d    = hi_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_o  = 1'b0;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = is_mul ? MUL : DIV;
        cnt_d   = '0;
        d_d     = is_mul ? abs_a : abs_b;
        p_d     = {32'd0, is_mul ? abs_b : abs_a};
        hi_d    = op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_MULHU || op_i == OP_REM || op_i == OP_REMU;
        qneg_d  = na ^ nb;
        rneg_d  = na;
      end
    end else begin
      p_d   = state_q == MUL ? mstep : dstep;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = IDLE;
        done_o  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: RV32I single-cycle ALU with optional iterative RV32M unit (macro ALU_MDU_EN)
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] alu_src1,
  input  logic [XLEN-1:0] alu_src2,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done
);
  logic [XLEN-1:0] result_q, result_d, quick, mdu_res;
  logic done_q, done_d, mdu_go, mdu_busy, mdu_fin, take_quick;
`ifdef ALU_MDU_EN
  logic div_zero, div_ovf, div_spec;
  assign div_zero = alu_src2 == '0;
  assign div_ovf  = (alu_op == OP_DIV || alu_op == OP_REM) && alu_src1 == INT_MIN && alu_src2 == '1;
  assign div_spec = alu_op >= OP_DIV && alu_op <= OP_REMU && (div_zero || div_ovf);
  assign mdu_go   = start && !mdu_busy && is_mdu(alu_op) && !div_spec;
  alu_mdu_iter u_mdu (
    .clk     (clk),
    .rst     (rst),
    .start_i (mdu_go),
    .op_i    (alu_op),
    .a_i     (alu_src1),
    .b_i     (alu_src2),
    .busy_o  (mdu_busy),
    .done_o  (mdu_fin),
    .res_o   (mdu_res)
  );
`else
  assign mdu_go   = 1'b0;
  assign mdu_busy = 1'b0;
  assign mdu_fin  = 1'b0;
  assign mdu_res  = '0;
`endif
  // single-cycle results, including the divide corner cases that skip iteration
  always_comb begin
    quick = '0;
    case (alu_op)
      OP_ADD:   quick = alu_src1 + alu_src2;
      OP_SUB:   quick = alu_src1 - alu_src2;
      OP_SLL:   quick = alu_src1 << alu_src2[4:0];
      OP_SLT:   quick = {{(XLEN-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
      OP_SLTU:  quick = {{(XLEN-1){1'b0}}, alu_src1 < alu_src2};
      OP_XOR:   quick = alu_src1 ^ alu_src2;
      OP_SRL:   quick = alu_src1 >> alu_src2[4:0];
      OP_SRA:   quick = $signed(alu_src1) >>> alu_src2[4:0];
      OP_OR:    quick = alu_src1 | alu_src2;
      OP_AND:   quick = alu_src1 & alu_src2;
      OP_PASSB: quick = alu_src2;
`ifdef ALU_MDU_EN
      OP_DIV:   quick = div_zero ? DIV0_QUOT : INT_MIN;
      OP_DIVU:  quick = DIV0_QUOT;
      OP_REM:   quick = div_zero ? alu_src1 : '0;
      OP_REMU:  quick = alu_src1;
`endif
      default:  quick = '0;
    endcase
  end
  assign take_quick = start && !mdu_busy && !mdu_go;
  assign result_d   = mdu_fin ? mdu_res : take_quick ? quick : result_q;
  assign done_d     = mdu_fin || take_quick;
  // result register and completion pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      done_q   <= done_d;
    end
  assign result = result_q;
  assign zero   = result_q == '0;
  assign busy   = mdu_busy;
  assign done   = done_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed scoreboard bench for alu_iter, expectations follow ALU_MDU_EN
module tb_alu_iter;
  import alu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [4:0] alu_op = '0;
  logic [31:0] alu_src1 = '0, alu_src2 = '0, result;
  logic zero, busy, done;
  int n_assert = 0, n_fail = 0;
  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_iter #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .alu_op   (alu_op),
    .alu_src1 (alu_src1),
    .alu_src2 (alu_src2),
    .result   (result),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MDU_EN
    logic [63:0] p;
    logic signed [31:0] s;
`endif
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return {31'b0, $signed(a) < $signed(b)};
      5'd4:  return {31'b0, a < b};
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return $signed(a) >>> b[4:0];
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
`ifdef ALU_MDU_EN
      5'd11: return a * b;
      5'd12: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      5'd13: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      5'd14: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd15: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        s = $signed(a) / $signed(b);
        return s;
      end
      5'd16: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
      5'd17: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        s = $signed(a) % $signed(b);
        return s;
      end
      5'd18: begin if (b == 0) return a; return a % b; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_MDU_EN
    if (op >= 5'd11 && op <= 5'd14) return 33;
    if (op >= 5'd15 && op <= 5'd18 && b != 0 &&
        !((op == 5'd15 || op == 5'd17) && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 33;
`endif
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    start = 1'b1;
    alu_op = op;
    alu_src1 = a;
    alu_src2 = b;
    e.res = model(op, a, b);
    e.lat = lat_of(op, a, b);
    sb.push_back(e);
  endtask

  task automatic collect(input string tag, input int poke);
    exp_t e;
    int cyc;
    e = sb.pop_front();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (poke != 0 && cyc == poke);
      alu_op = OP_ADD;
      alu_src1 = $urandom;
      alu_src2 = $urandom;
      if (cyc == 1) chk({tag, " busy1"}, {31'b0, busy}, {31'b0, e.lat > 1});
    end while (!done && cyc < 100);
    chk({tag, " latency"}, cyc, e.lat);
    chk({tag, " result"}, result, e.res);
    chk({tag, " zero"}, {31'b0, zero}, {31'b0, e.res == 0});
    chk({tag, " busy_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst result", result, 32'd0);
    chk("rst zero", {31'b0, zero}, 32'd1);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(OP_ADD, 32'h7FFFFFFF, 32'd1);          collect("add_ovf", 0);
    issue(OP_SUB, 32'd5, 32'd5);                 collect("sub_zero", 0);
    issue(OP_SRA, 32'h80000000, 32'h24);         collect("sra", 0);
    issue(OP_SLTU, 32'd1, 32'hFFFFFFFF);         collect("sltu", 0);
    issue(OP_SLT, 32'hFFFFFFFF, 32'd1);          collect("slt", 0);
    issue(OP_SLL, 32'h0000F00F, 32'h3F);         collect("sll", 0);
    issue(OP_SRL, 32'hF0000000, 32'd8);          collect("srl", 0);
    issue(OP_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F);   collect("xor", 0);
    issue(OP_OR, 32'h12340000, 32'h00005678);    collect("or", 0);
    issue(OP_AND, 32'hFF00FF00, 32'h0FF00FF0);   collect("and", 0);
    issue(OP_PASSB, 32'hDEADBEEF, 32'h00000004); collect("passb", 0);
    issue(5'd25, 32'd9, 32'd9);                  collect("illegal", 0);
    issue(OP_MULH, 32'hFFFFFFFE, 32'd3);         collect("mulh", 0);
    issue(OP_MUL, 32'hFFFFFFFE, 32'd3);          collect("mul", 0);
    issue(OP_MULHSU, 32'hFFFFFFFF, 32'd2);       collect("mulhsu", 0);
    issue(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF); collect("mulhu", 0);
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);          collect("div", 0);
    issue(OP_REM, 32'hFFFFFFF9, 32'd2);          collect("rem", 0);
    issue(OP_DIVU, 32'd7, 32'd0);                collect("divu_by0", 0);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);   collect("div_ovf", 0);
    issue(OP_REM, 32'h80000000, 32'hFFFFFFFF);   collect("rem_ovf", 0);
    issue(OP_REMU, 32'd13, 32'd0);               collect("remu_by0", 0);
    issue(OP_DIVU, 32'd100, 32'd7);              collect("divu_poke", 5);
    issue(OP_ADD, 32'd10, 32'd20);               collect("add_in_done", 0);
    issue(OP_REMU, 32'd100, 32'd7);              collect("remu", 0);
    @(negedge clk);
    chk("done single pulse", {31'b0, done}, 32'd0);
    issue(OP_MUL, 32'd5, 32'd7);
    sb.delete();
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst result", result, 32'd0);
    chk("midrst zero", {31'b0, zero}, 32'd1);
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_ADD, 32'd2, 32'd2);                 collect("add_after_rst", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
# alu_iter

Multi-cycle ALU that consumes the outputs of the ALU source-1 and source-2 selection muxes and produces a registered result for the write-back/PC-update logic of the multi-cycle core. Base RV32I operations complete in one cycle. RV32M multiply/divide operations run iteratively over 32 cycles. A start/busy/done handshake lets the control FSM stall in its execute state until the result is valid.

## Interface
Parameters:
- `XLEN`, 32, operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only while `busy`=0.
- `alu_op`  in  5  operation, `alu_op_e` from `alu_pkg`.
- `alu_src1`  in  32  operand A.
- `alu_src2`  in  32  operand B (4, imm or rs2 from the source-2 mux).
- `result`  out  32  registered result. Holds until the next completion.
- `zero`  out  1  `result`==0, combinational from the `result` register.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse: `result` is valid and was written this cycle.

## Operation
- Op encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - MUL=11, MULH=12, MULHSU=13, MULHU=14, DIV=15, DIVU=16, REM=17, REMU=18.
  - Codes 19–31 are illegal: result=0, handled as a single-cycle op.
- Shift ops use `alu_src2[4:0]`. SLT/SLTU produce 0 or 1.
- FSM states:
  - IDLE:
    - `start` with a single-cycle op: write `result`, set `done`, stay in IDLE.
    - `start` with a mul op: latch operands and go to MUL.
    - `start` with a div op: latch operands and go to DIV, unless it is a special case (below), which completes like a single-cycle op.
  - MUL / DIV: 5-bit counter runs 0..31. When count==31: write `result`, set `done`, go to IDLE.
- Operand latching: `alu_src1`/`alu_src2` are latched at the accepting edge. Later input changes are ignored.
- Multiply:
  - Shift-add on absolute values. Signedness per op: MULH s×s, MULHSU s×u, MULHU u×u, MUL any.
  - The 64-bit product is negated at completion if the operand signs differ.
  - MUL returns [31:0]; the MULH variants return [63:32].
- Divide:
  - Restoring division on absolute values.
  - Quotient sign = XOR of the operand signs. Remainder sign = dividend sign.
- Divide special cases (single-cycle):
  - Divisor 0: quotient=0xFFFFFFFF, remainder=dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- `start` while `busy`=1 is ignored with no side effects.
- `start` in the same cycle that `done`=1 is accepted (FSM is in IDLE).
- Reset, including mid-operation: state=IDLE, counter=0, `result`=0, `done`=0, `busy`=0, `zero`=1. Any in-flight operation is discarded.

## Timing
- Single-cycle op (start sampled at edge N):
  - `result` and `done` are valid in cycle N+1.
  - `busy` never rises.
  - Back-to-back single-cycle starts are accepted every cycle.
- Iterative op (start sampled at edge N):
  - `busy`=1 during cycles N+1..N+32.
  - `done`=1 and `result` valid in cycle N+33. `busy`=0 in that same cycle.
- `done` is high for exactly one cycle per accepted start.

## Configuration
- `ALU_MDU_EN` defined:
  - Ops 11–18 behave as above.
  - The MUL/DIV states and the iterative datapath are built.
- `ALU_MDU_EN` undefined:
  - Ops 11–18 are treated as illegal: result=0, single-cycle, `busy` is constant 0.
  - No iterative logic is synthesized.

## Structure
- `alu_pkg`:
  - `alu_op_e` (5-bit enum).
  - `alu_state_e` (IDLE, MUL, DIV).
  - Constants `DIV0_QUOT`=32'hFFFFFFFF and `INT_MIN`=32'h80000000.
- Sub-module `alu_mdu_iter`:
  - Owns the operand latches, the counter, and the shift-add / restoring datapath.
  - Handshake: `start`/`busy`/`done`.
  - Instantiated only under `ALU_MDU_EN`.

## Test plan
- ADD 0x7FFFFFFF+1: result=0x80000000 and `done` one cycle after start. SUB 5-5: result=0, `zero`=1.
- SRA 0x80000000 by src2=0x24 (shamt 4): result=0xF8000000. SLTU 1<0xFFFFFFFF: result=1.
- MULH 0xFFFFFFFE × 3: `busy` for 32 cycles, `done` at N+33, result=0xFFFFFFFF. MUL of the same operands: result=0xFFFFFFFA.
- DIV -7/2: quotient=0xFFFFFFFD. REM -7/2: result=0xFFFFFFFF. DIVU 7/0: result=0xFFFFFFFF with single-cycle `done`. DIV 0x80000000/0xFFFFFFFF: result=0x80000000.
- Pulse `start` (ADD) while DIVU is busy: ignored, and the DIVU result is unaffected. Pulse `start` in the `done` cycle: the new op completes.
- Assert `rst` at iteration 10 of MUL: outputs go to reset values immediately. A subsequent ADD 2+2 returns 4 in one cycle.
